// File: rtl/inst_mem_resp.sv
// Instruction-memory responder: valid/ack fetch port with LATENCY wait states plus a load port.
// Optional build macro INST_MEM_ALIGN_CHECK_EN flags misaligned fetch addresses as errors.
module inst_mem_resp #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 1,
  parameter string       INIT_FILE   = "",
  localparam int unsigned ADDR_W     = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_addr_i,
  input  logic              inst_req_i,
  output logic              inst_ready_o,
  output logic [31:0]       inst_o,
  output logic              inst_valid_o,
  input  logic              inst_ack_i,
  output logic              inst_err_o,
  input  logic              load_we_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [31:0]       load_data_i
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  if (LATENCY > 7) begin : g_bad_latency
    $fatal(1, "inst_mem_resp: LATENCY must be in 0..7");
  end
  if ((1 << ADDR_W) != DEPTH_WORDS) begin : g_bad_depth
    $fatal(1, "inst_mem_resp: DEPTH_WORDS must be a power of two");
  end

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              accept;
  logic              out_of_range;
  logic              misaligned;
  logic [ADDR_W-1:0] word_idx;

  assign word_idx     = inst_addr_i[ADDR_W+1:2];
  assign out_of_range = |inst_addr_i[31:ADDR_W+2];
  assign accept       = inst_req_i && (state_q == StIdle);

`ifdef INST_MEM_ALIGN_CHECK_EN
  assign misaligned = |inst_addr_i[1:0];
`else
  logic unused_byte_offset;
  assign misaligned         = 1'b0;
  assign unused_byte_offset = ^inst_addr_i[1:0];
`endif

  // RAM is not reset; the read below sees the pre-write value on a same-edge load.
  always_ff @(posedge clk) begin
    if (load_we_i) begin
      mem_q[load_addr_i] <= load_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      data_q  <= Nop;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          err_d   = out_of_range | misaligned;
          data_d  = (out_of_range | misaligned) ? Nop : mem_q[word_idx];
          cnt_d   = 3'(LATENCY);
          state_d = (LATENCY > 0) ? StWait : StResp;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (inst_ack_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    inst_ready_o = (state_q == StIdle);
    inst_valid_o = (state_q == StResp);
    inst_o       = data_q;
    inst_err_o   = err_q;
  end

endmodule

// File: tb/tb_inst_mem_resp.sv
// Scoreboard bench for inst_mem_resp: three instances (LATENCY 1, 0, 7) share the load bus.
module tb_inst_mem_resp;

  localparam int unsigned LATS [3] = '{1, 0, 7};

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [3];
  logic        ack   [3];
  logic [31:0] addr  [3];
  logic        ready [3];
  logic        valid [3];
  logic        err   [3];
  logic [31:0] data  [3];
  logic        we;
  logic [11:0] ld_addr;
  logic [31:0] ld_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          d;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inst_mem_resp #(
      .DEPTH_WORDS(4096),
      .LATENCY    (LATS[g])
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .inst_addr_i (addr[g]),
      .inst_req_i  (req[g]),
      .inst_ready_o(ready[g]),
      .inst_o      (data[g]),
      .inst_valid_o(valid[g]),
      .inst_ack_i  (ack[g]),
      .inst_err_o  (err[g]),
      .load_we_i   (we),
      .load_addr_i (ld_addr),
      .load_data_i (ld_data)
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation on every rising edge of a response valid.
  initial begin : monitor
    logic seen [3];
    exp_t e;
    for (int d = 0; d < 3; d++) seen[d] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (valid[d] === 1'b1 && !seen[d]) begin
          seen[d] = 1'b1;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_valid: dut %0d got valid=1 expected no response", d);
          end else begin
            e = exp_q.pop_front();
            chk("resp_dut", d, e.d);
            chk("resp_data", data[d], e.data);
            chk("resp_err", {31'd0, err[d]}, {31'd0, e.err});
          end
        end else if (valid[d] !== 1'b1) begin
          seen[d] = 1'b0;
        end
      end
    end
  end

  task automatic load(input logic [11:0] a, input logic [31:0] v);
    @(posedge clk); #1;
    we = 1'b1; ld_addr = a; ld_data = v;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic fetch(input int d, input logic [31:0] a, input logic [31:0] exp_d,
                       input logic exp_e, input int hold, input bit wr_same,
                       input logic [31:0] wr_data);
    exp_t e;
    int   lat;
    e.d = d; e.data = exp_d; e.err = exp_e;
    exp_q.push_back(e);
    @(posedge clk); #1;
    addr[d] = a;
    req[d]  = 1'b1;
    if (wr_same) begin
      we = 1'b1; ld_addr = a[13:2]; ld_data = wr_data;
    end
    @(negedge clk);
    chk("ready_idle", {31'd0, ready[d]}, 32'd1);
    @(posedge clk); #1;
    req[d] = 1'b0;
    we     = 1'b0;
    lat    = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (valid[d] === 1'b1) begin
        lat = i;
        break;
      end
      chk("ready_low_wait", {31'd0, ready[d]}, 32'd0);
    end
    chk("latency", lat, LATS[d] + 1);
    if (lat > 0) begin
      for (int k = 0; k < hold; k++) begin
        chk("hold_valid", {31'd0, valid[d]}, 32'd1);
        chk("hold_data", data[d], exp_d);
        chk("hold_ready", {31'd0, ready[d]}, 32'd0);
        @(negedge clk);
      end
      ack[d] = 1'b1;
      @(posedge clk); #1;
      ack[d] = 1'b0;
      @(negedge clk);
      chk("valid_after_ack", {31'd0, valid[d]}, 32'd0);
      chk("ready_after_ack", {31'd0, ready[d]}, 32'd1);
    end
  endtask

  task automatic abort(input int d, input bit in_resp, input logic [31:0] exp_d);
    exp_t e;
    if (in_resp) begin
      e.d = d; e.data = exp_d; e.err = 1'b0;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    addr[d] = 32'h0;
    req[d]  = 1'b1;
    @(posedge clk); #1;
    req[d] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(in_resp ? "pre_rst_resp" : "pre_rst_wait", {31'd0, valid[d]}, {31'd0, in_resp});
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'd0, valid[d]}, 32'd0);
    chk("rst_ready", {31'd0, ready[d]}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("no_stale_valid", {31'd0, valid[d]}, 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; we = 1'b0; ld_addr = '0; ld_data = '0;
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b0; ack[d] = 1'b0; addr[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_ready", {31'd0, ready[d]}, 32'd1);
      chk("reset_valid", {31'd0, valid[d]}, 32'd0);
      chk("reset_data", data[d], 32'h0000_0013);
      chk("reset_err", {31'd0, err[d]}, 32'd0);
    end

    load(12'd0, 32'h0050_0093);
    load(12'd1, 32'h0010_8113);
    load(12'd3, 32'h0000_0013);

    fetch(0, 32'h0, 32'h0050_0093, 1'b0, 0, 1'b0, 32'h0);
    fetch(0, 32'h4, 32'h0010_8113, 1'b0, 0, 1'b0, 32'h0);
    fetch(1, 32'h0, 32'h0050_0093, 1'b0, 0, 1'b0, 32'h0);
    fetch(2, 32'h4, 32'h0010_8113, 1'b0, 0, 1'b0, 32'h0);
    fetch(0, 32'h4, 32'h0010_8113, 1'b0, 5, 1'b0, 32'h0);

    fetch(0, 32'h0000_4000, 32'h0000_0013, 1'b1, 0, 1'b0, 32'h0);
    fetch(2, 32'h0000_4000, 32'h0000_0013, 1'b1, 0, 1'b0, 32'h0);
`ifdef INST_MEM_ALIGN_CHECK_EN
    fetch(0, 32'h2, 32'h0000_0013, 1'b1, 0, 1'b0, 32'h0);
`else
    fetch(0, 32'h2, 32'h0050_0093, 1'b0, 0, 1'b0, 32'h0);
`endif

    fetch(0, 32'hC, 32'h0000_0013, 1'b0, 0, 1'b1, 32'hDEAD_BEEF);
    fetch(0, 32'hC, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 32'h0);

    abort(2, 1'b0, 32'h0);
    abort(1, 1'b1, 32'h0050_0093);
    fetch(0, 32'h0, 32'h0050_0093, 1'b0, 0, 1'b0, 32'h0);
    fetch(2, 32'hC, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 32'h0);

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
